// File: rtl/clkdiv_delay_ctrl_if.sv
// Command handshake bundle between a training sequencer and the clock-divider delay controller.
interface clkdiv_delay_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_cnt;
  logic       busy;
  logic       done;

  modport master (output cmd_valid, cmd_op, cmd_cnt, input cmd_ready, busy, done);
  modport slave  (input cmd_valid, cmd_op, cmd_cnt, output cmd_ready, busy, done);
endinterface

// File: rtl/clkdiv_delay_ctrl.sv
// Sequences load/step/bitslip pulses to a clock-divider delay cell, tracking the tap
// index and a sticky range error, with a fixed settle window after every pulse.
module clkdiv_delay_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_TAP       = 255
) (
  input  logic                clk,
  input  logic                resetn,
  clkdiv_delay_ctrl_if.slave  cmd,
  input  logic                delay_line_out_of_range,
  output logic                delay_line_load,
  output logic                delay_line_move,
  output logic                delay_line_dir,
  output logic                bit_slip,
  output logic [7:0]          tap_val,
  output logic                oor_err
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, FINISH} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SLIP = 2'b11;

  localparam logic [7:0] MAX_TAP_V = 8'(MAX_TAP);
  localparam logic [3:0] SETTLE_V  = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic       armed_q;
  logic [1:0] op_q;
  logic [7:0] steps_q;
  logic [3:0] settle_q;
  logic [7:0] tap_q;
  logic       dir_q;
  logic       oor_q;

  logic accept;
  logic is_step;
  logic at_limit;
  logic fire;
  logic set_oor;

  assign accept   = cmd.cmd_valid && cmd.cmd_ready;
  assign is_step  = (op_q == OP_INC) || (op_q == OP_DEC);
  assign at_limit = ((op_q == OP_INC) && (tap_q == MAX_TAP_V)) ||
                    ((op_q == OP_DEC) && (tap_q == 8'd0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    set_oor = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = PULSE;
      end
      PULSE: begin
        // Zero-step and already-at-limit commands complete without touching the cell.
        if (is_step && (steps_q == 8'd0)) begin
          state_d = FINISH;
        end else if (is_step && at_limit) begin
          set_oor = 1'b1;
          state_d = FINISH;
        end else begin
          fire    = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          if (delay_line_out_of_range) begin
            set_oor = 1'b1;
            state_d = FINISH;
          end else if (is_step && (steps_q != 8'd0)) begin
            state_d = PULSE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= OP_LOAD;
      steps_q  <= 8'd0;
      settle_q <= 4'd0;
      tap_q    <= 8'd0;
      dir_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd.cmd_op;
        steps_q <= cmd.cmd_cnt;
        if (cmd.cmd_op == OP_INC) dir_q <= 1'b1;
        if (cmd.cmd_op == OP_DEC) dir_q <= 1'b0;
        if (cmd.cmd_op == OP_LOAD) oor_q <= 1'b0;
      end
      if (fire) begin
        settle_q <= SETTLE_V;
        case (op_q)
          OP_LOAD: tap_q <= 8'd0;
          OP_INC:  tap_q <= tap_q + 8'd1;
          OP_DEC:  tap_q <= tap_q - 8'd1;
          default: tap_q <= tap_q;
        endcase
        if (is_step) steps_q <= steps_q - 8'd1;
      end else if ((state_q == SETTLE) && (settle_q != 4'd0)) begin
        settle_q <= settle_q - 4'd1;
      end
      if (set_oor) oor_q <= 1'b1;
    end
  end

  // Pulses are decoded from state so an asserted reset clears them without waiting for an edge.
  assign cmd.cmd_ready   = armed_q && (state_q == IDLE);
  assign cmd.busy        = (state_q != IDLE);
  assign cmd.done        = (state_q == FINISH);
  assign delay_line_load = fire && (op_q == OP_LOAD);
  assign delay_line_move = fire && is_step;
  assign bit_slip        = fire && (op_q == OP_SLIP);
  assign delay_line_dir  = dir_q;
  assign tap_val         = tap_q;
  assign oor_err         = oor_q;

endmodule

// File: tb/tb_clkdiv_delay_ctrl.sv
// Randomized and directed bench for clkdiv_delay_ctrl against a command-level reference model.
module tb_clkdiv_delay_ctrl;

  localparam int S    = 4;
  localparam int MAXT = 255;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SLIP = 2'b11;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       oor_in = 1'b0;
  logic       load, move, dir, slip, oor;
  logic [7:0] tap;

  clkdiv_delay_ctrl_if bus();

  clkdiv_delay_ctrl #(.SETTLE_CYCLES(S), .MAX_TAP(MAXT)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .cmd                    (bus.slave),
    .delay_line_out_of_range(oor_in),
    .delay_line_load        (load),
    .delay_line_move        (move),
    .delay_line_dir         (dir),
    .bit_slip               (slip),
    .tap_val                (tap),
    .oor_err                (oor)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_tap = 0;
  int m_oor = 0;
  int m_dir = 0;

  // Observations of the last command run
  int r_npulse, r_wrong, r_done, r_first, r_gap_bad, r_ready_busy;

  task automatic model_cmd(input logic [1:0] op, input int cnt, input int abort_after,
                           output int e_pulses, output int e_lat);
    int room, n;
    if (op == OP_LOAD || op == OP_SLIP) begin
      e_pulses = 1;
      e_lat    = S + 2;
      if (op == OP_LOAD) begin
        m_tap = 0;
        m_oor = 0;
      end
    end else begin
      m_dir = (op == OP_INC) ? 1 : 0;
      room  = (op == OP_INC) ? (MAXT - m_tap) : m_tap;
      n     = (cnt < room) ? cnt : room;
      if (cnt == 0) begin
        e_lat = 2;
      end else if (abort_after > 0 && abort_after <= n) begin
        n     = abort_after;
        e_lat = n * (S + 1) + 1;
        m_oor = 1;
      end else if (n < cnt) begin
        e_lat = n * (S + 1) + 2;
        m_oor = 1;
      end else begin
        e_lat = n * (S + 1) + 1;
      end
      e_pulses = n;
      m_tap    = (op == OP_INC) ? m_tap + n : m_tap - n;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] cnt, input int abort_after);
    int k, guard, last, sel, all;
    r_npulse = 0; r_wrong = 0; r_done = -1; r_first = -1; r_gap_bad = 0; r_ready_busy = 0;
    last = -1; guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (r_done < 0 && k < 2000) begin
      sel = (op == OP_LOAD) ? int'(load) : (op == OP_SLIP) ? int'(slip) : int'(move);
      all = int'(load) + int'(move) + int'(slip);
      if (all != sel) r_wrong++;
      if (sel != 0) begin
        r_npulse++;
        if (r_first < 0) r_first = k;
        if (last >= 0 && (k - last) != S + 1) r_gap_bad++;
        last = k;
        if (abort_after > 0 && r_npulse == abort_after) oor_in = 1'b1;
      end
      if (bus.cmd_ready) r_ready_busy++;
      if (bus.done) r_done = k;
      @(negedge clk);
      k++;
    end
    oor_in = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_cnt = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({load, move, slip, dir, oor, bus.busy, bus.done} !== 7'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {load, move, slip, dir, oor, bus.busy, bus.done});
    end
    n_cmp++; if (tap !== 8'd0) begin n_bad++; $display("FAIL reset_tap: got %0d want 0", tap); end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_load;
    int ep, el;
    model_cmd(OP_LOAD, 0, 0, ep, el);
    run_cmd(OP_LOAD, 8'd0, 0);
    n_cmp++; if (r_first !== 1) begin n_bad++; $display("FAIL load_latency: got %0d want 1", r_first); end
    n_cmp++; if (r_npulse !== ep) begin n_bad++; $display("FAIL load_pulses: got %0d want %0d", r_npulse, ep); end
    n_cmp++; if (r_done !== el) begin n_bad++; $display("FAIL load_done: got %0d want %0d", r_done, el); end
    n_cmp++; if (int'(tap) !== m_tap) begin n_bad++; $display("FAIL load_tap: got %0d want %0d", tap, m_tap); end
    n_cmp++; if (r_wrong !== 0 || r_ready_busy !== 0) begin
      n_bad++; $display("FAIL load_side: got wrong=%0d ready=%0d want 0 0", r_wrong, r_ready_busy);
    end
  endtask

  task automatic test_inc3;
    int ep, el;
    model_cmd(OP_INC, 3, 0, ep, el);
    run_cmd(OP_INC, 8'd3, 0);
    n_cmp++; if (r_npulse !== ep) begin n_bad++; $display("FAIL inc3_pulses: got %0d want %0d", r_npulse, ep); end
    n_cmp++; if (r_gap_bad !== 0 || r_first !== 1) begin
      n_bad++; $display("FAIL inc3_spacing: got bad=%0d first=%0d want 0 1", r_gap_bad, r_first);
    end
    n_cmp++; if (r_done !== el) begin n_bad++; $display("FAIL inc3_done: got %0d want %0d", r_done, el); end
    n_cmp++; if (int'(tap) !== m_tap || int'(dir) !== m_dir) begin
      n_bad++; $display("FAIL inc3_state: got tap=%0d dir=%0d want %0d %0d", tap, dir, m_tap, m_dir);
    end
  endtask

  task automatic test_cnt_zero;
    int ep, el;
    model_cmd(OP_DEC, 0, 0, ep, el);
    run_cmd(OP_DEC, 8'd0, 0);
    n_cmp++; if (r_npulse !== ep || r_done !== el) begin
      n_bad++; $display("FAIL cnt_zero: got pulses=%0d done=%0d want %0d %0d", r_npulse, r_done, ep, el);
    end
    n_cmp++; if (int'(dir) !== m_dir || int'(tap) !== m_tap) begin
      n_bad++; $display("FAIL cnt_zero_state: got dir=%0d tap=%0d want %0d %0d", dir, tap, m_dir, m_tap);
    end
  endtask

  task automatic test_boundary;
    int ep, el;
    model_cmd(OP_LOAD, 0, 0, ep, el);
    run_cmd(OP_LOAD, 8'd0, 0);
    model_cmd(OP_INC, 254, 0, ep, el);
    run_cmd(OP_INC, 8'd254, 0);
    n_cmp++; if (tap !== 8'd254) begin n_bad++; $display("FAIL bnd_setup: got %0d want 254", tap); end
    model_cmd(OP_INC, 5, 0, ep, el);
    run_cmd(OP_INC, 8'd5, 0);
    n_cmp++; if (r_npulse !== ep || r_done !== el) begin
      n_bad++; $display("FAIL bnd_inc: got pulses=%0d done=%0d want %0d %0d", r_npulse, r_done, ep, el);
    end
    n_cmp++; if (int'(tap) !== m_tap || int'(oor) !== m_oor) begin
      n_bad++; $display("FAIL bnd_inc_state: got tap=%0d oor=%0d want %0d %0d", tap, oor, m_tap, m_oor);
    end
    model_cmd(OP_DEC, 1, 0, ep, el);
    run_cmd(OP_DEC, 8'd1, 0);
    n_cmp++; if (int'(tap) !== m_tap || int'(oor) !== m_oor || int'(dir) !== m_dir) begin
      n_bad++; $display("FAIL bnd_dec: got tap=%0d oor=%0d dir=%0d want %0d %0d %0d", tap, oor, dir, m_tap, m_oor, m_dir);
    end
    model_cmd(OP_LOAD, 0, 0, ep, el);
    run_cmd(OP_LOAD, 8'd0, 0);
    n_cmp++; if (int'(oor) !== m_oor || tap !== 8'd0) begin
      n_bad++; $display("FAIL bnd_load_clear: got oor=%0d tap=%0d want %0d 0", oor, tap, m_oor);
    end
    model_cmd(OP_DEC, 2, 0, ep, el);
    run_cmd(OP_DEC, 8'd2, 0);
    n_cmp++; if (r_npulse !== 0 || r_done !== el || int'(oor) !== m_oor || tap !== 8'd0) begin
      n_bad++; $display("FAIL bnd_dec_at_zero: got pulses=%0d done=%0d oor=%0d tap=%0d want 0 %0d %0d 0", r_npulse, r_done, oor, tap, el, m_oor);
    end
  endtask

  task automatic test_dec_abort;
    int ep, el;
    model_cmd(OP_LOAD, 0, 0, ep, el);
    run_cmd(OP_LOAD, 8'd0, 0);
    model_cmd(OP_INC, 10, 0, ep, el);
    run_cmd(OP_INC, 8'd10, 0);
    model_cmd(OP_DEC, 4, 2, ep, el);
    run_cmd(OP_DEC, 8'd4, 2);
    n_cmp++; if (r_npulse !== ep || r_done !== el) begin
      n_bad++; $display("FAIL abort_timing: got pulses=%0d done=%0d want %0d %0d", r_npulse, r_done, ep, el);
    end
    n_cmp++; if (int'(oor) !== m_oor || int'(tap) !== m_tap) begin
      n_bad++; $display("FAIL abort_state: got oor=%0d tap=%0d want %0d %0d", oor, tap, m_oor, m_tap);
    end
  endtask

  task automatic test_back_to_back;
    int k, slips, loads, rdy, done_k, guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    bus.cmd_op = OP_SLIP; bus.cmd_cnt = 8'd0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_op = OP_LOAD;
    k = 1; slips = 0; loads = 0; rdy = 0; done_k = -1;
    while (done_k < 0 && k < 100) begin
      if (slip) slips++;
      if (load) loads++;
      if (bus.cmd_ready) rdy++;
      if (bus.done) done_k = k;
      @(negedge clk);
      k++;
    end
    n_cmp++; if (slips !== 1 || loads !== 0 || rdy !== 0) begin
      n_bad++; $display("FAIL b2b_busy: got slips=%0d loads=%0d ready=%0d want 1 0 0", slips, loads, rdy);
    end
    n_cmp++; if (done_k !== S + 2) begin n_bad++; $display("FAIL b2b_done: got %0d want %0d", done_k, S + 2); end
    n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: got ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_cmp++; if (load !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got load=%b want 1", load); end
    m_tap = 0; m_oor = 0;
    guard = 0;
    while (!bus.done && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
  endtask

  task automatic test_random;
    int ep, el, r, cnt, ab;
    logic [1:0] op;
    for (int i = 0; i < 25; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r == 0) ? OP_LOAD : (r == 1) ? OP_SLIP : (r < 6) ? OP_INC : OP_DEC;
      cnt = int'($urandom_range(0, 6));
      ab  = (op != OP_LOAD && op != OP_SLIP && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      model_cmd(op, cnt, ab, ep, el);
      run_cmd(op, 8'(cnt), ab);
      n_cmp++; if (r_npulse !== ep || r_done !== el || r_wrong !== 0 || r_gap_bad !== 0) begin
        n_bad++; $display("FAIL rand_%0d op=%0d cnt=%0d ab=%0d: got pulses=%0d done=%0d wrong=%0d gaps=%0d want %0d %0d 0 0",
                          i, op, cnt, ab, r_npulse, r_done, r_wrong, r_gap_bad, ep, el);
      end
      n_cmp++; if (int'(tap) !== m_tap || int'(oor) !== m_oor || int'(dir) !== m_dir) begin
        n_bad++; $display("FAIL rand_state_%0d: got tap=%0d oor=%0d dir=%0d want %0d %0d %0d", i, tap, oor, dir, m_tap, m_oor, m_dir);
      end
    end
  endtask

  task automatic test_reset_mid;
    int ep, el, guard, dones;
    model_cmd(OP_LOAD, 0, 0, ep, el);
    run_cmd(OP_LOAD, 8'd0, 0);
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    bus.cmd_op = OP_INC; bus.cmd_cnt = 8'd8; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({load, move, slip, dir, oor, bus.busy, bus.done} !== 7'b0 || tap !== 8'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b tap=%0d want 0 0", {load, move, slip, dir, oor, bus.busy, bus.done}, tap);
    end
    m_tap = 0; m_oor = 0; m_dir = 0;
    dones = 0;
    repeat (3) begin @(negedge clk); if (bus.done) dones++; end
    resetn = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.done) dones++; end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midreset_done: got %0d want 0", dones); end
    n_cmp++; if (bus.cmd_ready !== 1'b1 || tap !== 8'd0) begin
      n_bad++; $display("FAIL midreset_ready: got ready=%b tap=%0d want 1 0", bus.cmd_ready, tap);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc3();
    test_cnt_zero();
    test_boundary();
    test_dec_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
